// File: rtl/nios_system_cpu_3_oci_dct_packer.sv
// rtl/nios_system_cpu_3_oci_dct_packer.sv - packs 2-bit DCT trace codes into packets for the OCI trace path
// Codes shift into an accumulator; a full, flushed or end-of-test accumulator moves to the output slot.
module nios_system_cpu_3_oci_dct_packer #(
  parameter int ENTRIES = 15,
  parameter int CODE_W  = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        dct_in_valid,
  input  logic [CODE_W-1:0]           dct_in_code,
  output logic                        dct_in_ready,
  input  logic                        flush,
  input  logic                        test_ending,
  output logic [ENTRIES*CODE_W-1:0]   dct_buffer,
  output logic [3:0]                  dct_count,
  output logic                        dct_out_valid,
  input  logic                        dct_out_ready,
  output logic                        test_has_ended
);

  localparam int         BUF_W = ENTRIES * CODE_W;
  localparam logic [3:0] FULL  = 4'(ENTRIES);

  logic [BUF_W-1:0] acc_q, acc_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       count_q, count_d;
  logic             pend_q, pend_d;
  logic             valid_q, valid_d;
  logic             ended_q, ended_d;

  logic slot_free;
  logic acc_nonempty;
  logic xfer;
  logic accept;

  always_comb begin
    slot_free    = !valid_q || dct_out_ready;
    acc_nonempty = (cnt_q != 4'd0);
    xfer         = slot_free && ((cnt_q == FULL) || ((pend_q || test_ending) && acc_nonempty));
    // A transfer empties the accumulator this cycle, so a full accumulator still takes a code.
    dct_in_ready = reset_n && ((cnt_q < FULL) || xfer);
    accept       = dct_in_valid && dct_in_ready;

    acc_d   = acc_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    count_d = count_q;
    valid_d = valid_q;
    pend_d  = pend_q;
    ended_d = ended_q;

    if (xfer) begin
      buf_d   = acc_q;
      count_d = cnt_q;
      valid_d = 1'b1;
      acc_d   = accept ? BUF_W'(dct_in_code) : '0;
      cnt_d   = accept ? 4'd1 : 4'd0;
      // A flush arriving with a code that lands in the fresh accumulator must still push it out.
      pend_d  = flush && accept;
    end else begin
      if (accept) begin
        acc_d = {acc_q[BUF_W-CODE_W-1:0], dct_in_code};
        cnt_d = cnt_q + 4'd1;
      end
      if (dct_out_ready) begin
        valid_d = 1'b0;
      end
      if (flush && (acc_nonempty || accept)) begin
        pend_d = 1'b1;
      end
    end

    if (test_ending && !acc_nonempty && !accept && slot_free) begin
      ended_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q   <= '0;
      cnt_q   <= 4'd0;
      buf_q   <= '0;
      count_q <= 4'd0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      ended_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      ended_q <= ended_d;
    end
  end

  assign dct_buffer     = buf_q;
  assign dct_count      = count_q;
  assign dct_out_valid  = valid_q;
  assign test_has_ended = ended_q;

endmodule
